// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, issues one synchronous imem read per cycle
// and buffers returned words with their PC in a small FIFO presented over valid/ready.
module inst_fetch_ctrl #(
    parameter int          ADDR_W    = 5,
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int          BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_en,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              imem_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [31:0]       inst_pc
);

    localparam int CW  = $clog2(BUF_DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    localparam logic [CW:0]   DEPTH_W  = CW1'(BUF_DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(BUF_DEPTH - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   req_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [PW-1:0] head, tail;
    logic [31:0]   fifo_inst [BUF_DEPTH];
    logic [31:0]   fifo_pc   [BUF_DEPTH];
    logic          pop, push;
    logic [CW:0]   credit;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (fetch_en)  state_nxt = RUN;
            RUN:     if (!fetch_en) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign inst_valid = (count != '0);

    // A request is only issued when its response is guaranteed a FIFO slot, counting the
    // in-flight word and any head popped this cycle.
    always_comb begin
        pop     = inst_valid & inst_ready & ~redirect;
        push    = inflight & ~redirect;
        credit  = {1'b0, count} + {{CW{1'b0}}, inflight} - {{CW{1'b0}}, pop};
        imem_en = (state == RUN) & fetch_en & ~redirect & ~rst & (credit < DEPTH_W);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            req_pc   <= '0;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            inflight <= imem_en;
            if (imem_en) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 32'd1;
            end
            if (push) tail <= next_ptr(tail);
            if (pop)  head <= next_ptr(head);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // NOTE: FIFO storage has no reset; count gates its visibility, so stale entries are never seen.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            fifo_inst[tail] <= imem_rdata;
            fifo_pc[tail]   <= req_pc;
        end
    end

    assign imem_addr = fetch_pc[ADDR_W-1:0];
    assign inst      = inst_valid ? fifo_inst[head] : 32'h0;
    assign inst_pc   = inst_valid ? fifo_pc[head]   : 32'h0;

endmodule
